// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serialiser; one bit lasts 4*CLK_DIV clk cycles.
// Optional feature: define UART_TX_PARITY_EN to insert an even parity bit before the stop bit.
module uart_tx #(
    parameter int CLK_DIV = 108,
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tvalid,
    output logic               tready,
    input  logic [7:0]         tdata,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;

    state_t             state_q;
    logic               tx_q;
    logic [7:0]         shift_q;
    logic [2:0]         bit_idx_q;
    logic [PW-1:0]      presc_q;
    logic [1:0]         quarter_q;
`ifdef UART_TX_PARITY_EN
    logic               parity_q;
`endif

    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               bit_tick;
    logic [7:0]         head;

    assign fifo_empty = (count_q == '0);
    assign tready     = (count_q != (FIFO_AW+1)'(DEPTH));
    assign push       = tvalid & tready;
    assign head       = mem_q[rd_ptr_q];
    assign bit_tick   = (presc_q == PW'(CLK_DIV - 1)) && (quarter_q == 2'd3);
    // The head is taken either straight from idle or at the end of a stop bit.
    assign pop        = !fifo_empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_tick));

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign fifo_count = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        count_d = count_q + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            shift_q   <= '0;
            bit_idx_q <= '0;
            presc_q   <= '0;
            quarter_q <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            // Restarting the prescaler on every pop keeps each bit exactly 4*CLK_DIV long.
            if ((state_q == S_IDLE) || pop) begin
                presc_q   <= '0;
                quarter_q <= '0;
            end else if (presc_q == PW'(CLK_DIV - 1)) begin
                presc_q   <= '0;
                quarter_q <= quarter_q + 2'd1;
            end else begin
                presc_q   <= presc_q + PW'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        shift_q <= head;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^head;
`endif
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end else begin
                        tx_q    <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_tick) begin
                        tx_q      <= shift_q[0];
                        bit_idx_q <= '0;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_tick) begin
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_tick) begin
                        if (pop) begin
                            shift_q <= head;
`ifdef UART_TX_PARITY_EN
                            parity_q <= ^head;
`endif
                            tx_q    <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter, the counterpart of the team's existing UART receiver. Same baud convention: baud = clk / (4*CLK_DIV).
- Accepts bytes over a valid/ready interface into a small internal FIFO. Serialises them as 8N1 frames (start, 8 data bits LSB first, stop).
- Sits between user logic and the board TX pin. Loopback to the receiver at the same CLK_DIV must deliver every byte intact.

Parameters:
- CLK_DIV, 108, quarter-bit divider. One bit period = 4*CLK_DIV clk cycles. Legal range >= 1.
- FIFO_AW, 3, FIFO address width. FIFO depth = 2**FIFO_AW bytes. Legal range 1..8.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- tvalid  input  1  user has a byte to send
- tready  output  1  FIFO can accept a byte (high = not full)
- tdata  input  8  byte to send, sampled when tvalid & tready at a rising clk edge
- tx  output  1  serial line, idle high, registered output
- busy  output  1  high while a frame is on the line or the FIFO is non-empty
- fifo_count  output  FIFO_AW+1  number of bytes currently buffered (excluding the byte being shifted)

Behaviour:
- Reset values (asynchronous, immediate on rst_n low):
  - tx = 1, busy = 0, fifo_count = 0, tready = 1.
  - FIFO pointers 0, FSM in IDLE, prescaler and bit counter 0.
- Reset mid-frame aborts the frame (tx goes high at once) and discards all buffered bytes.
- FIFO:
  - Push on clk edge when tvalid & tready.
  - tready = (fifo_count != 2**FIFO_AW). Combinational from the registered count, no dependence on tvalid.
  - Pointers wrap modulo 2**FIFO_AW. fifo_count has one extra bit so "full" is distinguishable from "empty".
  - Simultaneous push and pop: count unchanged, both happen.
  - Push while full is impossible (tready=0). tvalid while full has no effect; the user holds data until tready.
- Prescaler:
  - Counts 0..CLK_DIV-1 and emits a quarter tick on CLK_DIV-1.
  - A 2-bit quarter counter yields a bit tick every 4 quarter ticks.
  - Prescaler and quarter counter are cleared when a frame starts, so every bit lasts exactly 4*CLK_DIV cycles.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into an internal shift register, drive tx=0, go to START. Otherwise tx=1.
  - START: on bit tick, go to DATA, tx = shift[0], bit index = 0.
  - DATA: on each bit tick, shift right and increment the index. After bit index 7 completes, drive tx=1 and go to STOP.
  - STOP: on bit tick, if the FIFO is non-empty, pop and go directly to START with tx=0 (back-to-back, no idle gap). Otherwise go to IDLE with tx=1.
- Timing:
  - Latency: handshake at edge N, FIFO count 1 after N, pop and tx falls at edge N+1. The start bit is visible 1 cycle after the accepting edge.
  - Frame length = 40*CLK_DIV cycles. Continuous streaming gives one frame per 40*CLK_DIV cycles.
- tdata changes while held or not accepted never alter a frame in flight; data is captured at push.
- busy = (state != IDLE) | (fifo_count != 0). Registered or derived from registered state only.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - An even parity bit (XOR of the 8 data bits) is inserted between the last data bit and the stop bit, via a PARITY state of one bit period.
  - Frame = 11 bits = 44*CLK_DIV cycles.
- Undefined: no PARITY state or parity logic is synthesised; 8N1 as above.
- Default build leaves it undefined, matching the team's receiver.

Test Plan:
- Reset, then hold idle 100 cycles with CLK_DIV=4 -> tx=1, tready=1, busy=0, fifo_count=0 throughout.
- CLK_DIV=4, push 0xA5 once -> tx low 1 cycle after the handshake edge for 16 cycles, then bits 1,0,1,0,0,1,0,1 for 16 cycles each, then stop high 16 cycles. busy drops after 160 cycles.
- CLK_DIV=4, FIFO_AW=2, push 6 bytes 0x00..0x05 with tvalid held high:
  - tready deasserts when fifo_count=4 (one byte already in the shifter).
  - The remaining byte is accepted when the next pop frees a slot.
  - Frames are back-to-back with no idle gap; 960 cycles total.
- Loopback tx to the UART receiver, CLK_DIV=8, random 256-byte stream -> receiver rvalid pulses 256 times with identical data in order.
- Assert rst_n low 70 cycles into a frame with 3 bytes buffered -> tx=1 immediately. After release, fifo_count=0 and busy=0; no further frames are sent.
- With UART_TX_PARITY_EN defined, push 0x07 -> parity bit 1 after data, frame length 176 cycles at CLK_DIV=4. Push 0x03 -> parity bit 0.
